// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU MEM stage has priority over the debug/loader burst port,
// with a starvation counter that forces a debug win after STARVE_MAX denied cycles.
module dmem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 10,
    parameter int LW         = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [LW-1:0] dbg_len,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE,
        DBG_BURST
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_addr_q, base_addr_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic [LW-1:0] last_beat_q, last_beat_d;
    logic          burst_we_q, burst_we_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          dbg_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            base_addr_q  <= '0;
            beat_cnt_q   <= '0;
            last_beat_q  <= '0;
            burst_we_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            base_addr_q  <= base_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            last_beat_q  <= last_beat_d;
            burst_we_q   <= burst_we_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Outputs are gated by reset so an asynchronous reset idles the RAM port at once.
    always_comb begin
        state_d      = state_q;
        base_addr_d  = base_addr_q;
        beat_cnt_d   = beat_cnt_q;
        last_beat_d  = last_beat_q;
        burst_we_d   = burst_we_q;
        starve_cnt_d = starve_cnt_q;
        dbg_win      = 1'b0;
        cpu_gnt      = 1'b0;
        dbg_gnt      = 1'b0;
        dbg_done     = 1'b0;
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;

        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    dbg_win = dbg_req & (~cpu_req | (starve_cnt_q == SW'(STARVE_MAX)));
                    if (dbg_win) begin
                        dbg_gnt      = 1'b1;
                        ram_addr     = dbg_addr;
                        ram_we       = dbg_we;
                        ram_wdata    = dbg_wdata;
                        base_addr_d  = dbg_addr;
                        burst_we_d   = dbg_we;
                        last_beat_d  = dbg_len;
                        starve_cnt_d = '0;
                        if (dbg_len == '0) begin
                            dbg_done = 1'b1;
                        end else begin
                            beat_cnt_d = LW'(1);
                            state_d    = DBG_BURST;
                        end
                    end else begin
                        if (cpu_req) begin
                            cpu_gnt   = 1'b1;
                            ram_addr  = cpu_addr;
                            ram_we    = cpu_we;
                            ram_wdata = cpu_wdata;
                        end
                        if (dbg_req && (starve_cnt_q != SW'(STARVE_MAX))) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
                DBG_BURST: begin
                    if (dbg_req) begin
                        dbg_gnt   = 1'b1;
                        ram_addr  = base_addr_q + AW'(beat_cnt_q);
                        ram_we    = burst_we_q;
                        ram_wdata = dbg_wdata;
                        if (beat_cnt_q == last_beat_q) begin
                            dbg_done   = 1'b1;
                            beat_cnt_d = '0;
                            state_d    = IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign cpu_rdata = ram_rdata;
    assign dbg_rdata = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural RAM model plus hand-computed
// expectations for CPU access, bursts, starvation, wrap, abort and reset.
module tb_dmem_arbiter;

    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we;
    logic [9:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_stall;
    logic [9:0] cpu_rdata;
    logic       dbg_req, dbg_we;
    logic [9:0] dbg_addr;
    logic [3:0] dbg_len;
    logic [9:0] dbg_wdata;
    logic       dbg_gnt, dbg_done;
    logic [9:0] dbg_rdata;
    logic [9:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we;

    logic [9:0] mem [1024];
    logic       capWe;
    logic [9:0] capAddr, capData;
    int         passed = 0;
    int         total  = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    // RAM model: write port captured shortly before each rising edge, committed on it.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[1022] = 10'h111;
        mem[1023] = 10'h222;
        mem[0]    = 10'h333;
        forever begin
            @(negedge clk);
            #4;
            capWe   = ram_we;
            capAddr = ram_addr;
            capData = ram_wdata;
            @(posedge clk);
            if (capWe) mem[capAddr] = capData;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [9:0] ca,
                                 input logic [9:0] cd, input logic dr, input logic dw,
                                 input logic [9:0] da, input logic [3:0] dl,
                                 input logic [9:0] dd);
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_len = dl; dbg_wdata = dd;
        #1;
    endtask

    initial begin
        // Reset held with active requests: nothing may reach the RAM.
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'($urandom); cpu_wdata = 10'($urandom);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'($urandom); dbg_len = 4'($urandom);
        dbg_wdata = 10'($urandom);
        #1;
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_cpu_gnt", cpu_gnt, 0);
        checkOutput("rst_dbg_gnt", dbg_gnt, 0);
        applyStimulus(1, 1, 10'($urandom), 10'($urandom), 1, 1, 10'($urandom), 4'($urandom), 10'($urandom));
        checkOutput("rst2_ram_we", ram_we, 0);
        checkOutput("rst2_gnt", {cpu_gnt, dbg_gnt}, 0);
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
        rst = 1'b1;

        // CPU store then load at address 5.
        applyStimulus(1, 1, 10'd5, 10'h2A, 0, 0, 0, 0, 0);
        checkOutput("st_gnt", cpu_gnt, 1);
        checkOutput("st_stall", cpu_stall, 0);
        checkOutput("st_ram_addr", ram_addr, 5);
        checkOutput("st_ram_we", ram_we, 1);
        applyStimulus(1, 0, 10'd5, 10'h0, 0, 0, 0, 0, 0);
        checkOutput("ld_gnt", cpu_gnt, 1);
        checkOutput("ld_rdata", cpu_rdata, 10'h2A);

        // Four-beat debug write at 100; address/len changes after beat 0 are ignored.
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd100, 4'd3, 10'd1);
        checkOutput("bw0_gnt", dbg_gnt, 1);
        checkOutput("bw0_addr", ram_addr, 100);
        checkOutput("bw0_done", dbg_done, 0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 10'd7, 4'd0, 10'(i + 1));
            checkOutput("bw_gnt", dbg_gnt, 1);
            checkOutput("bw_addr", ram_addr, 100 + i);
            checkOutput("bw_we", ram_we, 1);
            checkOutput("bw_done", dbg_done, (i == 3) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 10'd7, 4'd0, 0);
        checkOutput("bw_after_gnt", dbg_gnt, 1);
        checkOutput("bw_after_addr", ram_addr, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mem100", mem[100], 1);
        checkOutput("mem101", mem[101], 2);
        checkOutput("mem102", mem[102], 3);
        checkOutput("mem103", mem[103], 4);

        // Starvation: CPU wins four cycles, debug wins the fifth.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 10'd5, 0, 1, 0, 10'd100, 4'd1, 0);
            checkOutput("sv_cpu_gnt", cpu_gnt, 1);
            checkOutput("sv_dbg_gnt", dbg_gnt, 0);
        end
        applyStimulus(1, 0, 10'd5, 0, 1, 0, 10'd100, 4'd1, 0);
        checkOutput("sv5_dbg_gnt", dbg_gnt, 1);
        checkOutput("sv5_stall", cpu_stall, 1);
        checkOutput("sv5_rdata", dbg_rdata, 1);
        applyStimulus(1, 0, 10'd5, 0, 1, 0, 10'd100, 4'd0, 0);
        checkOutput("sv6_addr", ram_addr, 101);
        checkOutput("sv6_stall", cpu_stall, 1);
        checkOutput("sv6_done", dbg_done, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 10'd5, 0, 1, 0, 10'd100, 4'd0, 0);
            checkOutput("sv_re_cpu_gnt", cpu_gnt, 1);
            checkOutput("sv_re_rdata", cpu_rdata, 10'h2A);
        end
        applyStimulus(1, 0, 10'd5, 0, 1, 0, 10'd100, 4'd0, 0);
        checkOutput("sv_len0_gnt", dbg_gnt, 1);
        checkOutput("sv_len0_done", dbg_done, 1);
        checkOutput("sv_len0_cpu", cpu_gnt, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sv_idle", {cpu_gnt, dbg_gnt, ram_we}, 0);

        // Wrap-around read burst from 1022.
        applyStimulus(0, 0, 0, 0, 1, 0, 10'd1022, 4'd2, 0);
        checkOutput("wr0_addr", ram_addr, 1022);
        checkOutput("wr0_rdata", dbg_rdata, 10'h111);
        applyStimulus(0, 0, 0, 0, 1, 0, 10'd1022, 4'd2, 0);
        checkOutput("wr1_addr", ram_addr, 1023);
        checkOutput("wr1_rdata", dbg_rdata, 10'h222);
        checkOutput("wr1_done", dbg_done, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 10'd1022, 4'd2, 0);
        checkOutput("wr2_addr", ram_addr, 0);
        checkOutput("wr2_rdata", dbg_rdata, 10'h333);
        checkOutput("wr2_done", dbg_done, 1);

        // Abort after two beats of an eight-beat write.
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd200, 4'd7, 10'h50);
        checkOutput("ab0_gnt", dbg_gnt, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd200, 4'd7, 10'h51);
        checkOutput("ab1_addr", ram_addr, 201);
        applyStimulus(1, 0, 10'd5, 0, 0, 1, 10'd200, 4'd7, 10'h52);
        checkOutput("ab2_we", ram_we, 0);
        checkOutput("ab2_gnt", {cpu_gnt, dbg_gnt, dbg_done}, 0);
        checkOutput("ab2_stall", cpu_stall, 1);
        applyStimulus(1, 0, 10'd5, 0, 0, 1, 10'd200, 4'd7, 10'h53);
        checkOutput("ab3_cpu_gnt", cpu_gnt, 1);
        checkOutput("ab3_rdata", cpu_rdata, 10'h2A);
        checkOutput("ab_mem201", mem[201], 10'h51);
        checkOutput("ab_mem202", mem[202], 0);

        // Asynchronous reset during the third beat of a six-beat write.
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd300, 4'd5, 10'h60);
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd300, 4'd5, 10'h61);
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd300, 4'd5, 10'h62);
        checkOutput("rb2_addr", ram_addr, 302);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rb_rst_gnt", dbg_gnt, 0);
        checkOutput("rb_rst_we", ram_we, 0);
        dbg_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd400, 4'd1, 10'h70);
        checkOutput("rb_new0_addr", ram_addr, 400);
        checkOutput("rb_new0_gnt", dbg_gnt, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 10'd400, 4'd1, 10'h71);
        checkOutput("rb_new1_addr", ram_addr, 401);
        checkOutput("rb_new1_done", dbg_done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rb_mem301", mem[301], 10'h61);
        checkOutput("rb_mem302", mem[302], 0);
        checkOutput("rb_mem303", mem[303], 0);
        checkOutput("rb_mem400", mem[400], 10'h70);
        checkOutput("rb_mem401", mem[401], 10'h71);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
